// File: rtl/encoder_pkg.sv
// Shared widths and idle encoding for the 8-to-3 priority encoder.
package encoder_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_IDLE = 3'b000;

endpackage

// File: rtl/prio_enc8_comb.sv
// Combinational 8-to-3 priority encoder: highest-numbered set request wins.
module prio_enc8_comb
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        idx     = IDX_IDLE;
        any_req = 1'b0;
        // Ascending scan: a later (higher) set line overwrites any lower one.
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                idx     = IDX_W'(i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder with enable and valid flag (1-cycle latency).
module encoder_8x3
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic a5,
    input  logic a6,
    input  logic a7,
    output logic x0,
    output logic x1,
    output logic x2,
    output logic v
);

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] enc_idx;
    logic             any_req;
    logic [IDX_W-1:0] idx_q;
    logic             v_q;

    assign req = {a7, a6, a5, a4, a3, a2, a1, a0};

    prio_enc8_comb u_prio (
        .req     (req),
        .idx     (enc_idx),
        .any_req (any_req)
    );

    // Disabled or no request both collapse to idle; only v distinguishes a0 from idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            idx_q <= IDX_IDLE;
            v_q   <= 1'b0;
        end else if (en && any_req) begin
            idx_q <= enc_idx;
            v_q   <= 1'b1;
        end else begin
            idx_q <= IDX_IDLE;
            v_q   <= 1'b0;
        end
    end

    assign x0 = idx_q[0];
    assign x1 = idx_q[1];
    assign x2 = idx_q[2];
    assign v  = v_q;

endmodule

// File: tb/tb_encoder_8x3.sv
// Self-checking bench for encoder_8x3: directed cases plus randomized stream vs. a behavioural model.
module tb_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       x0, x1, x2, v;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_out = 4'b0000;   // {v, x2, x1, x0}
    logic       cmp_en = 1'b0;

    encoder_8x3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a0    (req[0]),
        .a1    (req[1]),
        .a2    (req[2]),
        .a3    (req[3]),
        .a4    (req[4]),
        .a5    (req[5]),
        .a6    (req[6]),
        .a7    (req[7]),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .v     (v)
    );

    always #5 clk = ~clk;

    // Reference: index of the highest set line is floor(log2(req)), found by shifting down.
    function automatic logic [3:0] model(input logic e, input logic [7:0] r);
        logic [7:0] t;
        int         n;
        if (!e || r == 8'h00) return 4'b0000;
        t = r;
        n = 0;
        while (t > 8'd1) begin
            t = t >> 1;
            n++;
        end
        return {1'b1, 3'(n)};
    endfunction

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got {v,x}=%b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model register mirrors the async clear and the one-cycle sampling of the outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_out <= 4'b0000;
        else        exp_out <= model(en, req);
    end

    always @(negedge clk) begin
        if (cmp_en) check("stream", {v, x2, x1, x0}, exp_out);
    end

    initial begin
        // Reset asserted with a request pending: outputs clear without any clock edge.
        #1;
        rst_n  = 1'b0;
        en     = 1'b1;
        req    = 8'h80;
        cmp_en = 1'b1;
        #2;
        check("reset_immediate", {v, x2, x1, x0}, 4'b0000);
        step();
        step();
        check("reset_held", {v, x2, x1, x0}, 4'b0000);

        // Enable low ignores requests.
        rst_n = 1'b1;
        en    = 1'b0;
        req   = 8'h08;
        step();
        check("disabled", {v, x2, x1, x0}, 4'b0000);

        // One-hot sweep a0..a7.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req = 8'h01 << i;
            step();
            check($sformatf("sweep_a%0d", i), {v, x2, x1, x0}, {1'b1, 3'(i)});
        end

        // Idle versus a0 alone.
        req = 8'h00;
        step();
        check("idle", {v, x2, x1, x0}, 4'b0000);
        req = 8'h01;
        step();
        check("a0_only", {v, x2, x1, x0}, 4'b1000);

        // Priority cases.
        req = 8'h24;
        step();
        check("prio_a2_a5", {v, x2, x1, x0}, 4'b1101);
        req = 8'h52;
        step();
        check("prio_a1_a4_a6", {v, x2, x1, x0}, 4'b1110);
        req = 8'h12;
        step();
        check("prio_drop_a6", {v, x2, x1, x0}, 4'b1100);

        // Async reset mid-sweep, between edges.
        req = 8'h08;
        step();
        check("pre_reset_a3", {v, x2, x1, x0}, 4'b1011);
        #1;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", {v, x2, x1, x0}, 4'b0000);
        step();
        check("midstream_held", {v, x2, x1, x0}, 4'b0000);
        rst_n = 1'b1;
        req   = 8'h20;
        step();
        check("resume_a5", {v, x2, x1, x0}, 4'b1101);

        // Randomized stream checked on every negedge by the compare process.
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'h01 << $urandom_range(0, 7);
                default: req = 8'($urandom);
            endcase
            if ($urandom_range(0, 31) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_reset", {v, x2, x1, x0}, 4'b0000);
                rst_n = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
